decode: RTL
===========

DECODE -- requirements
Module: decode

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high; sampled on rising edge of clk.
REQ-003 pipe_flush  input  1  fetch-issued squash of the slot currently in IF/ID.
REQ-004 if_id__pc  input  32  PC of the fetched instruction.
REQ-005 if_id__ins  input  32  fetched instruction word.
REQ-006 if_id__predict_taken  input  1  BTB taken prediction for the slot.
REQ-007 if_id__predict_target  input  32  BTB predicted target for the slot.
REQ-008 if_id__data_hazard  input  1  slot is a stall replay; not retirable.
REQ-009 if_id__instret  input  1  slot is a retirable instruction.
REQ-010 wb__rd_write  input  1  writeback enable.
REQ-011 wb__rd_index  input  5  writeback destination register.
REQ-012 wb__rd_data  input  32  writeback data.
REQ-013 data_hazard  output  1  combinational load-use stall request to fetch.
REQ-014 id_ex__pc, id_ex__imm, id_ex__rs1_data, id_ex__rs2_data, id_ex__predict_target  output  32 each  registered decode results.
REQ-015 id_ex__rs1_index, id_ex__rs2_index, id_ex__rd_index  output  5 each  registered register indices.
REQ-016 id_ex__opcode  output  5  ins[6:2]; id_ex__funct3 output 3 ins[14:12]; id_ex__funct7_5 output 1 ins[30].
REQ-017 id_ex__load, id_ex__predict_taken, id_ex__instret, id_ex__valid  output  1 each  registered flags.

Function
REQ-018 Register file SHALL hold 31 writable 32-bit registers; index 0 SHALL always read 0 and ignore writes.
REQ-019 Register writes SHALL occur on rising edge when wb__rd_write=1 and wb__rd_index!=0.
REQ-020 Reads SHALL bypass same-cycle writeback: if wb__rd_write=1, wb__rd_index!=0 and equals a read index, read data SHALL be wb__rd_data.
REQ-021 Immediate SHALL be sign-extended per opcode: I (LOAD, OP-IMM, JALR, SYSTEM), S (STORE), B (BRANCH, bit0=0), U (LUI, AUIPC, low 12 bits 0), J (JAL, bit0=0); other opcodes yield 0.
REQ-022 uses_rs1 SHALL be 1 for all opcodes except LUI, AUIPC, JAL; uses_rs2 SHALL be 1 only for OP, STORE, BRANCH.
REQ-023 rd_index SHALL be ins[11:7] for opcodes writing rd, else forced to 0 (STORE, BRANCH).
REQ-024 data_hazard SHALL be 1 iff id_ex__valid=1, id_ex__load=1, id_ex__rd_index!=0, pipe_flush=0, and (uses_rs1 and rs1==id_ex__rd_index, or uses_rs2 and rs2==id_ex__rd_index).
REQ-025 Slot is live iff pipe_flush=0, if_id__data_hazard=0, data_hazard=0.
REQ-026 Live slot: on next edge all id_ex__ outputs SHALL latch decoded values; id_ex__valid=1; id_ex__instret=if_id__instret.
REQ-027 Non-live slot: on next edge SHALL insert bubble: id_ex__valid=0, id_ex__instret=0, id_ex__load=0, id_ex__rd_index=0, id_ex__predict_taken=0; other fields don't-care.
REQ-028 Latency SHALL be exactly one cycle IF/ID to ID/EX; no internal buffering beyond ID/EX register.
REQ-029 Load-use stall SHALL last exactly one cycle: the inserted bubble clears the condition of REQ-024 for the replayed slot.
REQ-030 pipe_flush and data_hazard simultaneous: flush SHALL take priority; data_hazard SHALL be 0.
REQ-031 Writeback to a register matching a stalled slot's source SHALL be visible on replay via REQ-019/020.

Reset
REQ-032 While rst=1 at an edge: id_ex__valid=0, id_ex__instret=0, id_ex__load=0, id_ex__predict_taken=0, all other id_ex__ outputs 0.
REQ-033 Register file contents SHALL NOT be reset; x0 reads 0 regardless.
REQ-034 rst mid-stall SHALL clear the stall; first cycle after rst deasserts data_hazard=0.

Verification
REQ-035 Write x5=0x12345678 via wb; then decode ADD x6,x5,x0 -> id_ex__rs1_data=0x12345678, rs2_data=0, rd=6, valid=1.
REQ-036 LW x7,0(x1) then ADD x8,x7,x7 -> data_hazard=1 one cycle, bubble (valid=0, instret=0), ADD issues next cycle.
REQ-037 LW x0,0(x1) then ADD x8,x0,x0 -> data_hazard stays 0.
REQ-038 BEQ with imm=-4 (ins=0xFE000EE3) -> id_ex__imm=0xFFFFFFFC, rd_index=0, uses_rs2 path selected.
REQ-039 pipe_flush=1 coincident with load-use condition -> data_hazard=0, bubble latched, next live slot decodes normally.
REQ-040 wb write x9=0xA5A5A5A5 same cycle as decode reading x9 -> id_ex__rs1_data=0xA5A5A5A5.

Source files
------------

// File: rtl/decode.sv
// Instruction decode stage: register file with writeback bypass,
// immediate generation, load-use hazard detection and the ID/EX register.
module decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_flush,
  input  logic [31:0] if_id__pc,
  input  logic [31:0] if_id__ins,
  input  logic        if_id__predict_taken,
  input  logic [31:0] if_id__predict_target,
  input  logic        if_id__data_hazard,
  input  logic        if_id__instret,
  input  logic        wb__rd_write,
  input  logic [4:0]  wb__rd_index,
  input  logic [31:0] wb__rd_data,
  output logic        data_hazard,
  output logic [31:0] id_ex__pc,
  output logic [31:0] id_ex__imm,
  output logic [31:0] id_ex__rs1_data,
  output logic [31:0] id_ex__rs2_data,
  output logic [31:0] id_ex__predict_target,
  output logic [4:0]  id_ex__rs1_index,
  output logic [4:0]  id_ex__rs2_index,
  output logic [4:0]  id_ex__rd_index,
  output logic [4:0]  id_ex__opcode,
  output logic [2:0]  id_ex__funct3,
  output logic        id_ex__funct7_5,
  output logic        id_ex__load,
  output logic        id_ex__predict_taken,
  output logic        id_ex__instret,
  output logic        id_ex__valid
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  logic [31:0] rf_q [32];

  logic [31:0] ins;
  logic [4:0]  opc, rs1, rs2, rd_d;
  logic        is_i, is_s, is_b, is_u, is_j;
  logic        is_load, use1, use2, wb_hit;
  logic [31:0] imm_d, rs1_d, rs2_d;
  logic        live;
  logic        unused_ins;

  assign ins        = if_id__ins;
  assign opc        = ins[6:2];
  assign rs1        = ins[19:15];
  assign rs2        = ins[24:20];
  assign unused_ins = ^ins[1:0];

  assign is_load = opc == OP_LOAD;
  assign is_i    = is_load || opc == OP_IMM
                || opc == OP_JALR || opc == OP_SYSTEM;
  assign is_s    = opc == OP_STORE;
  assign is_b    = opc == OP_BRANCH;
  assign is_u    = opc == OP_LUI || opc == OP_AUIPC;
  assign is_j    = opc == OP_JAL;

  assign use1 = !(is_u || is_j);
  assign use2 = opc == OP_OP || is_s || is_b;
  assign rd_d = (is_s || is_b) ? 5'd0 : ins[11:7];

  always_comb begin
    imm_d = '0;
    unique case (1'b1)
      is_i: imm_d = {{20{ins[31]}}, ins[31:20]};
      is_s: imm_d = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      is_b: imm_d = {{19{ins[31]}}, ins[31], ins[7],
                     ins[30:25], ins[11:8], 1'b0};
      is_u: imm_d = {ins[31:12], 12'd0};
      is_j: imm_d = {{11{ins[31]}}, ins[31], ins[19:12],
                     ins[20], ins[30:21], 1'b0};
      default: imm_d = '0;
    endcase
  end

  assign wb_hit = wb__rd_write && wb__rd_index != 5'd0;

  always_comb begin
    rs1_d = '0;
    rs2_d = '0;
    if (rs1 != 5'd0)
      rs1_d = (wb_hit && wb__rd_index == rs1) ? wb__rd_data : rf_q[rs1];
    if (rs2 != 5'd0)
      rs2_d = (wb_hit && wb__rd_index == rs2) ? wb__rd_data : rf_q[rs2];
  end

  // A bubble in ID/EX drops valid, so a stall can never repeat on replay.
  assign data_hazard = id_ex__valid && id_ex__load
                    && id_ex__rd_index != 5'd0 && !pipe_flush
                    && ((use1 && rs1 == id_ex__rd_index)
                     || (use2 && rs2 == id_ex__rd_index));

  assign live = !pipe_flush && !if_id__data_hazard && !data_hazard;

  always_ff @(posedge clk) begin
    if (wb_hit)
      rf_q[wb__rd_index] <= wb__rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex__pc             <= '0;
      id_ex__imm            <= '0;
      id_ex__rs1_data       <= '0;
      id_ex__rs2_data       <= '0;
      id_ex__predict_target <= '0;
      id_ex__rs1_index      <= '0;
      id_ex__rs2_index      <= '0;
      id_ex__rd_index       <= '0;
      id_ex__opcode         <= '0;
      id_ex__funct3         <= '0;
      id_ex__funct7_5       <= 1'b0;
      id_ex__load           <= 1'b0;
      id_ex__predict_taken  <= 1'b0;
      id_ex__instret        <= 1'b0;
      id_ex__valid          <= 1'b0;
    end else begin
      id_ex__pc             <= if_id__pc;
      id_ex__imm            <= imm_d;
      id_ex__rs1_data       <= rs1_d;
      id_ex__rs2_data       <= rs2_d;
      id_ex__predict_target <= if_id__predict_target;
      id_ex__rs1_index      <= rs1;
      id_ex__rs2_index      <= rs2;
      id_ex__rd_index       <= live ? rd_d : 5'd0;
      id_ex__opcode         <= opc;
      id_ex__funct3         <= ins[14:12];
      id_ex__funct7_5       <= ins[30];
      id_ex__load           <= live && is_load;
      id_ex__predict_taken  <= live && if_id__predict_taken;
      id_ex__instret        <= live && if_id__instret;
      id_ex__valid          <= live;
    end
  end

endmodule
